if_write_address_generator: RTL

- Write-side address generator for the input-feature (IF) scratchpad, which is used as a circular buffer.
- Accepts IF elements from the upstream input buffer with a valid/ready handshake and issues write enables and write pointers.
- Tracks complete rows and publishes start_row/end_row/rows_available to the read-side address generator.
- Frees a row's entries when the reader signals release_row; stalls the producer when the scratchpad is full.

---
 rtl/if_pkg.sv | 16 +
 rtl/if_write_address_generator_circ_ptr_add.sv | 22 ++
 rtl/if_write_address_generator.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the IF scratchpad write-side address generator.
`default_nettype none

package if_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Occupancy and row counts must hold the value SPAD_DEPTH itself.
    localparam int OCC_EXTRA_BITS = 1;

endpackage

`default_nettype wire

// File: rtl/if_write_address_generator_circ_ptr_add.sv
// Combinational circular pointer add: (ptr + inc) mod SPAD_DEPTH, inc <= SPAD_DEPTH.
`default_nettype none

module circ_ptr_add #(
    parameter int POINTER_SIZE = 4,
    parameter int SPAD_DEPTH   = 16
) (
    input  logic [POINTER_SIZE-1:0] ptr_i,
    input  logic [POINTER_SIZE:0]   inc_i,
    output logic [POINTER_SIZE-1:0] sum_o
);

    localparam logic [POINTER_SIZE:0] DEPTH = (POINTER_SIZE + 1)'(SPAD_DEPTH);

    logic [POINTER_SIZE:0] w_sum;

    assign w_sum = {1'b0, ptr_i} + inc_i;
    assign sum_o = POINTER_SIZE'((w_sum >= DEPTH) ? (w_sum - DEPTH) : w_sum);

endmodule

`default_nettype wire

// File: rtl/if_write_address_generator.sv
// Write-side address generator for the circular IF scratchpad: accepts elements,
// tracks complete rows for the reader and frees rows on release_row.
`default_nettype none

module if_write_address_generator
    import if_pkg::*;
#(
    parameter int POINTER_SIZE     = 4,
    parameter int SPAD_DEPTH       = 16,
    parameter int ROW_LEN_REG_SIZE = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [ROW_LEN_REG_SIZE-1:0] row_len_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic                        release_row_i,
    output logic                        write_en_o,
    output logic [POINTER_SIZE-1:0]     write_pointer_o,
    output logic [POINTER_SIZE-1:0]     start_row_o,
    output logic [POINTER_SIZE-1:0]     end_row_o,
    output logic [POINTER_SIZE:0]       rows_available_o,
    output logic                        row_done_o
);

    localparam int OCC_WIDTH = POINTER_SIZE + OCC_EXTRA_BITS;
    localparam logic [OCC_WIDTH-1:0]        DEPTH_OCC = OCC_WIDTH'(SPAD_DEPTH);
    localparam logic [ROW_LEN_REG_SIZE:0]   LEN_MAX   = (ROW_LEN_REG_SIZE + 1)'(SPAD_DEPTH);
    localparam logic [ROW_LEN_REG_SIZE-1:0] LEN_ONE   = ROW_LEN_REG_SIZE'(1);
    localparam logic [POINTER_SIZE:0]       PTR_ONE   = (POINTER_SIZE + 1)'(1);

    state_t                      state_q, state_d;
    logic [POINTER_SIZE-1:0]     wp_q, wp_d;
    logic [ROW_LEN_REG_SIZE-1:0] col_cnt_q, col_cnt_d;
    logic [OCC_WIDTH-1:0]        occ_q, occ_d;
    logic [ROW_LEN_REG_SIZE-1:0] len_q, len_d;
    logic [POINTER_SIZE:0]       rows_q, rows_d;
    logic [POINTER_SIZE-1:0]     start_row_q, start_row_d;
    logic [POINTER_SIZE-1:0]     end_row_q, end_row_d;
    logic                        row_done_q, row_done_d;

    logic                        w_legal_start;
    logic                        w_write;
    logic                        w_last;
    logic                        w_row_cmp;
    logic                        w_release;
    logic [POINTER_SIZE:0]       w_len_ext;
    logic [POINTER_SIZE-1:0]     w_wp_next;
    logic [POINTER_SIZE-1:0]     w_start_next;

    assign w_legal_start = start_i && (row_len_i != '0) && ({1'b0, row_len_i} <= LEN_MAX);

    // Ready depends only on registered state, never on release_row.
    assign in_ready_o = (state_q == RUN) && (occ_q < DEPTH_OCC);
    assign w_write    = in_valid_i && in_ready_o;
    assign w_last     = (col_cnt_q == (len_q - LEN_ONE));
    assign w_row_cmp  = w_write && w_last;
    assign w_release  = (state_q == RUN) && release_row_i && (rows_q != '0);
    assign w_len_ext  = (POINTER_SIZE + 1)'(len_q);

    circ_ptr_add #(
        .POINTER_SIZE (POINTER_SIZE),
        .SPAD_DEPTH   (SPAD_DEPTH)
    ) u_wp_add (
        .ptr_i (wp_q),
        .inc_i (PTR_ONE),
        .sum_o (w_wp_next)
    );

    circ_ptr_add #(
        .POINTER_SIZE (POINTER_SIZE),
        .SPAD_DEPTH   (SPAD_DEPTH)
    ) u_start_add (
        .ptr_i (start_row_q),
        .inc_i (w_len_ext),
        .sum_o (w_start_next)
    );

    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        col_cnt_d   = col_cnt_q;
        occ_d       = occ_q;
        len_d       = len_q;
        rows_d      = rows_q;
        start_row_d = start_row_q;
        end_row_d   = end_row_q;
        row_done_d  = 1'b0;

        if (w_legal_start) begin
            // Restart discards any partial row and ignores same-cycle traffic.
            state_d     = RUN;
            len_d       = row_len_i;
            wp_d        = '0;
            col_cnt_d   = '0;
            occ_d       = '0;
            rows_d      = '0;
            start_row_d = '0;
            end_row_d   = '0;
        end else if (state_q == RUN) begin
            if (w_write) begin
                wp_d      = w_wp_next;
                col_cnt_d = w_last ? '0 : (col_cnt_q + LEN_ONE);
                if (w_last) begin
                    end_row_d = wp_q;
                end
            end
            if (w_release) begin
                start_row_d = w_start_next;
            end
            occ_d      = occ_q + OCC_WIDTH'(w_write) - (w_release ? OCC_WIDTH'(len_q) : '0);
            rows_d     = rows_q + (POINTER_SIZE + 1)'(w_row_cmp) - (POINTER_SIZE + 1)'(w_release);
            row_done_d = w_row_cmp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wp_q        <= '0;
            col_cnt_q   <= '0;
            occ_q       <= '0;
            len_q       <= '0;
            rows_q      <= '0;
            start_row_q <= '0;
            end_row_q   <= '0;
            row_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            col_cnt_q   <= col_cnt_d;
            occ_q       <= occ_d;
            len_q       <= len_d;
            rows_q      <= rows_d;
            start_row_q <= start_row_d;
            end_row_q   <= end_row_d;
            row_done_q  <= row_done_d;
        end
    end

    assign write_en_o       = w_write;
    assign write_pointer_o  = wp_q;
    assign start_row_o      = start_row_q;
    assign end_row_o        = end_row_q;
    assign rows_available_o = rows_q;
    assign row_done_o       = row_done_q;

endmodule

`default_nettype wire
